// File: rtl/inst_rom.sv
// Loadable instruction ROM: a loader streams the program image in, then the
// core fetches words with zero read latency until the next reset.
module inst_rom #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst,
    input  logic                  load_valid,
    input  logic [31:0]           load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  rom_valid,
    output logic [DEPTH_LOG2:0]   word_count,
    output logic [31:0]           fetch_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [31:0]             mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr_r;
    logic [DEPTH_LOG2:0]     word_count_r;
    logic [31:0]             fetch_count_r;

    logic                    accept_s;
    logic                    full_s;
    logic                    serve_s;
    logic [DEPTH_LOG2-1:0]   idx_s;
    logic                    hit_s;

    assign serve_s  = (state_r == ST_SERVE);
    assign accept_s = load_valid && !serve_s;
    assign full_s   = (wptr_r == {DEPTH_LOG2{1'b1}});
    assign idx_s    = addr[DEPTH_LOG2+1:2];

    // A fetch hits only an aligned, in-window address inside the loaded image.
    assign hit_s = ce && serve_s
                   && (addr[1:0] == 2'b00)
                   && (addr[31:DEPTH_LOG2+2] == '0)
                   && ({1'b0, idx_s} < word_count_r);

    // State register; reset wins over everything on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: the image is closed by load_last or by filling the array.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_EMPTY, ST_LOAD: begin
                if (accept_s && (load_last || full_s)) begin
                    next_state_s = ST_SERVE;
                end else if (accept_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_SERVE: next_state_s = ST_SERVE;
            default:  next_state_s = ST_EMPTY;
        endcase
    end

    // Loader write pointer and loaded-word counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_r       <= '0;
            word_count_r <= '0;
        end else if (accept_s) begin
            wptr_r       <= wptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            word_count_r <= word_count_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
        end else begin
            wptr_r       <= wptr_r;
            word_count_r <= word_count_r;
        end
    end

    // Image storage is deliberately not cleared; word_count gates visibility.
    always_ff @(posedge clk) begin
        if (rst && accept_s) begin
            mem_r[wptr_r] <= load_data;
        end
    end

    // Served-fetch counter, saturating instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count_r <= 32'h0000_0000;
        end else if (ce && serve_s && (fetch_count_r != 32'hFFFF_FFFF)) begin
            fetch_count_r <= fetch_count_r + 32'h0000_0001;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    // Zero-latency read so the core captures PC and instruction together.
    always_comb begin
        inst = 32'h0000_0000;
        if (hit_s) begin
            inst = mem_r[idx_s];
        end else begin
            inst = 32'h0000_0000;
        end
    end

    assign load_ready  = !serve_s;
    assign rom_valid   = serve_s;
    assign word_count  = word_count_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, gives log2 of the word capacity (1024 x 32-bit words).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 ce  input  1  fetch enable from the core PC stage.
REQ-005 addr  input  32  fetch byte address from the core PC stage.
REQ-006 inst  output  32  fetched instruction word, combinational from addr/ce/state.
REQ-007 load_valid  input  1  loader beat valid.
REQ-008 load_data  input  32  loader instruction word.
REQ-009 load_last  input  1  marks the final loader beat.
REQ-010 load_ready  output  1  block accepts a loader beat this cycle.
REQ-011 rom_valid  output  1  image loaded; fetches are served.
REQ-012 word_count  output  DEPTH_LOG2+1  number of words loaded.
REQ-013 fetch_count  output  32  number of served fetch cycles.

Function
REQ-014 FSM states are EMPTY, LOAD and SERVE; there is no other state.
REQ-015 EMPTY: load_ready=1 and rom_valid=0; an accepted beat (load_valid & load_ready) moves the FSM to LOAD, or to SERVE if load_last=1.
REQ-016 LOAD: load_ready=1 and rom_valid=0; an accepted beat with load_last=1 moves the FSM to SERVE.
REQ-017 Accepted beat: mem[wptr] <= load_data, wptr and word_count increment by 1, all in the same edge.
REQ-018 Full: an accepted beat at wptr = 2^DEPTH_LOG2-1 moves the FSM to SERVE regardless of load_last; word_count = 2^DEPTH_LOG2.
REQ-019 SERVE: load_ready=0, rom_valid=1; load_valid is ignored and memory and word_count are frozen; SERVE is left only by reset.
REQ-020 Word index idx = addr[DEPTH_LOG2+1:2].
REQ-021 inst = mem[idx] only when all of the following hold: ce=1, state=SERVE, addr[1:0]=0, addr[31:DEPTH_LOG2+2]=0 and idx < word_count.
REQ-022 In every other case inst = 32'h0, including misaligned, out-of-range, unloaded-word, ce=0 and pre-SERVE fetches.
REQ-023 Read latency is zero cycles: inst reflects the current addr in the same cycle, so the core's IF/ID register captures the PC and the instruction together.
REQ-024 A beat written on edge N is readable from the cycle after edge N, provided the FSM is in SERVE.
REQ-025 fetch_count increments by 1 on each edge where ce=1 and state=SERVE, whether or not inst is 0.
REQ-026 fetch_count saturates at 32'hFFFFFFFF and does not wrap.
REQ-027 Simultaneous load_valid and ce before SERVE: the beat is accepted, inst=0 and fetch_count is unchanged.

Reset
REQ-028 While rst=0 at an edge, the block sets state=EMPTY, wptr=0, word_count=0 and fetch_count=0.
REQ-029 During and after reset the outputs are load_ready=1, rom_valid=0 and inst=0.
REQ-030 Memory contents are not cleared by reset; after reset they are unreadable until reloaded because word_count=0.
REQ-031 Reset asserted mid-load (LOAD) or mid-service (SERVE) discards the image in the same edge; any concurrent beat is not written.
REQ-032 Reset has priority over every other event on the same edge.

Verification
REQ-033 Load 4 beats 32'h02800401, 32'h02800802, 32'h00101403, 32'h03400000 (last on beat 4), then ce=1 with addr=0x0,0x4,0x8,0xC -> inst returns those 4 words in order, word_count=4, fetch_count=4.
REQ-034 After the REQ-033 load, addr=0x10 (unloaded), addr=0x2 (misaligned) and addr=0x1000 (out of range, DEPTH_LOG2=10), each with ce=1 -> inst=0 in every case, and fetch_count increments for each.
REQ-035 Load 1024 beats with load_last=0 throughout -> SERVE is entered after beat 1024, load_ready=0, and a 1025th load_valid beat is ignored (mem[0] unchanged).
REQ-036 Reset pulse after 2 of 4 beats -> word_count=0 and rom_valid=0; then reload 1 beat 32'hDEADBEEF with load_last=1 -> inst=32'hDEADBEEF at addr=0 and inst=0 at addr=4.
REQ-037 ce=1 before any load -> inst=0, fetch_count=0; with fetch_count preset to 32'hFFFFFFFE by forcing, three SERVE fetches -> fetch_count=32'hFFFFFFFF.
